out_port_unit: RTL and testbench

Parametrised successor to the single 32-bit Out register. It provides NUM_CH output channels, each selectable from the datapath bus by the "out" instruction's write strobe. Each channel runs in one of two modes. Latch mode keeps the legacy Out register behaviour. Stream mode adds a DEPTH-entry FIFO that drains to an external device over a valid/ready handshake. The block sits between BusMuxOut and the board-level output pins.

---
 rtl/out_port_pkg.sv | 16 +
 rtl/out_port_if.sv | 26 ++
 rtl/out_port_chan.sv | 83 ++++++++
 rtl/out_port_unit.sv | 48 ++++
 tb/tb_out_port_unit.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/out_port_pkg.sv
// Shared constants and width helpers for the output port unit and its channels.
package out_port_pkg;

  localparam logic MODE_LATCH  = 1'b0;
  localparam logic MODE_STREAM = 1'b1;

  // Channel select is at least one bit wide even for a single channel.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/out_port_if.sv
// Write-side bus and board-side output pins of the output port unit.
interface out_port_if import out_port_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4
);
  localparam int CH_W = sel_w(NUM_CH);

  logic [DATA_W-1:0]        bus_in;
  logic                     out_wr;
  logic [CH_W-1:0]          ch_sel;
  logic                     wr_stall;
  logic [NUM_CH*DATA_W-1:0] port_data;
  logic [NUM_CH-1:0]        port_valid;
  logic [NUM_CH-1:0]        port_ready;

  modport master (
    output bus_in, out_wr, ch_sel, port_ready,
    input  wr_stall, port_data, port_valid
  );

  modport slave (
    input  bus_in, out_wr, ch_sel, port_ready,
    output wr_stall, port_data, port_valid
  );

endinterface

// File: rtl/out_port_chan.sv
// One output channel: legacy latch register or a small FIFO drained over valid/ready.
module out_port_chan import out_port_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              mode,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              ready,
  input  logic              ovf_clr,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              full,
  output logic              ovf
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic              mode_sh;
  logic [CNT_W-1:0]  cnt;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] hold;
  logic              lvalid;

  logic mode_chg, stream, at_max, pop, push_ok, drop;

  always_comb begin
    mode_chg = (mode != mode_sh);
    stream   = (mode_sh == MODE_STREAM);
    at_max   = (cnt == CNT_MAX);
    pop      = stream && (cnt != '0) && ready;
    // A full FIFO still accepts a word when the head leaves on the same edge.
    push_ok  = push && !mode_chg && (!at_max || pop);
    drop     = push && !mode_chg && stream && at_max && !pop;
    full     = stream && at_max && !pop;
    valid    = stream ? (cnt != '0) : lvalid;
    data     = stream ? ((cnt != '0) ? mem[rd_ptr] : '0) : hold;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mode_sh <= MODE_LATCH;
      cnt     <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      hold    <= '0;
      lvalid  <= 1'b0;
      ovf     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      mode_sh <= mode;
      if (mode_chg) begin
        // Switching modes flushes the channel and swallows any write this cycle.
        cnt    <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        hold   <= '0;
        lvalid <= 1'b0;
      end else if (!stream) begin
        if (push) begin
          hold   <= push_data;
          lvalid <= 1'b1;
        end
      end else begin
        if (push_ok) begin
          mem[wr_ptr] <= push_data;
          wr_ptr      <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        if (push_ok && !pop)      cnt <= cnt + CNT_W'(1);
        else if (pop && !push_ok) cnt <= cnt - CNT_W'(1);
      end
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/out_port_unit.sv
// Multi-channel output port: decodes the out-instruction write onto NUM_CH channels.
module out_port_unit import out_port_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              clr,
  out_port_if.slave         bus,
  input  logic [NUM_CH-1:0] mode,
  input  logic [NUM_CH-1:0] ovf_clr,
  output logic [NUM_CH-1:0] overflow
);
  localparam int CH_W = sel_w(NUM_CH);

  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] valid;
  logic [DATA_W-1:0] ch_data [NUM_CH];

  // Out-of-range selects match no channel, so the write simply vanishes.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign push[g] = bus.out_wr && (bus.ch_sel == CH_W'(g));

    out_port_chan #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_chan (
      .clk       (clk),
      .clr       (clr),
      .mode      (mode[g]),
      .push      (push[g]),
      .push_data (bus.bus_in),
      .ready     (bus.port_ready[g]),
      .ovf_clr   (ovf_clr[g]),
      .data      (ch_data[g]),
      .valid     (valid[g]),
      .full      (full[g]),
      .ovf       (overflow[g])
    );
  end

  assign bus.wr_stall   = |(push & full);
  assign bus.port_valid = valid;

  always_comb begin
    bus.port_data = '0;
    for (int i = 0; i < NUM_CH; i++) bus.port_data[i*DATA_W +: DATA_W] = ch_data[i];
  end

endmodule

// File: tb/tb_out_port_unit.sv
// Self-checking bench for out_port_unit: directed scenarios plus a randomized run against a queue model.
module tb_out_port_unit;
  localparam int DW  = 32;
  localparam int NCH = 4;
  localparam int DEP = 4;

  logic clk = 1'b0;
  logic clr;
  logic [NCH-1:0] mode, ovf_clr, overflow;
  logic [2:0] mode3, ovf_clr3, overflow3;

  out_port_if #(.DATA_W(DW), .NUM_CH(NCH)) bus ();
  out_port_if #(.DATA_W(DW), .NUM_CH(3))   bus3 ();

  out_port_unit #(.DATA_W(DW), .NUM_CH(NCH), .DEPTH(DEP)) u_dut (
    .clk(clk), .clr(clr), .bus(bus), .mode(mode), .ovf_clr(ovf_clr), .overflow(overflow)
  );

  out_port_unit #(.DATA_W(DW), .NUM_CH(3), .DEPTH(2)) u_dut3 (
    .clk(clk), .clr(clr), .bus(bus3), .mode(mode3), .ovf_clr(ovf_clr3), .overflow(overflow3)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: per-channel queue, latch value, effective mode and sticky flag.
  logic [31:0] mq [NCH][$];
  logic        m_sh  [NCH];
  logic [31:0] lat_d [NCH];
  logic        lat_v [NCH];
  logic        m_ovf [NCH];

  function automatic logic [31:0] pd(input int c);
    return bus.port_data[c*DW +: DW];
  endfunction

  function automatic logic [31:0] exp_d(input int c);
    if (m_sh[c]) return (mq[c].size() != 0) ? mq[c][0] : 32'h0;
    return lat_d[c];
  endfunction

  function automatic logic exp_v(input int c);
    if (m_sh[c]) return mq[c].size() != 0;
    return lat_v[c];
  endfunction

  function automatic logic exp_stall(input logic wr, input logic [1:0] sel, input logic [3:0] rdy);
    int c = int'(sel);
    return wr && m_sh[c] && (mq[c].size() == DEP) && !rdy[c];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      m_sh[c] = 1'b0; lat_d[c] = '0; lat_v[c] = 1'b0; m_ovf[c] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic wr, input logic [1:0] sel, input logic [31:0] d,
                            input logic [3:0] md, input logic [3:0] rdy, input logic [3:0] oc);
    for (int c = 0; c < NCH; c++) begin
      logic drop, hit, was_full, pop;
      drop = 1'b0;
      hit  = wr && (int'(sel) == c);
      if (md[c] != m_sh[c]) begin
        mq[c].delete(); lat_v[c] = 1'b0; lat_d[c] = '0; m_sh[c] = md[c];
      end else if (!m_sh[c]) begin
        if (hit) begin lat_d[c] = d; lat_v[c] = 1'b1; end
      end else begin
        was_full = (mq[c].size() == DEP);
        pop      = (mq[c].size() != 0) && rdy[c];
        if (pop) void'(mq[c].pop_front());
        if (hit) begin
          if (!was_full || pop) mq[c].push_back(d);
          else drop = 1'b1;
        end
      end
      if (drop)       m_ovf[c] = 1'b1;
      else if (oc[c]) m_ovf[c] = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    mode = '0; ovf_clr = '0; mode3 = '0; ovf_clr3 = '0;
    bus.bus_in = '0; bus.out_wr = 1'b0; bus.ch_sel = '0; bus.port_ready = '0;
    bus3.bus_in = '0; bus3.out_wr = 1'b0; bus3.ch_sel = '0; bus3.port_ready = '0;
    step();
    step();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.port_valid !== 4'h0) begin n_fail++; $display("FAIL reset_valid: got %h expected 0", bus.port_valid); end
    n_cmp++; if (bus.port_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", bus.port_data); end
    n_cmp++; if (overflow !== 4'h0) begin n_fail++; $display("FAIL reset_ovf: got %h expected 0", overflow); end
    n_cmp++; if (bus.wr_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", bus.wr_stall); end
    n_cmp++; if (bus3.port_valid !== 3'h0) begin n_fail++; $display("FAIL reset_valid3: got %h expected 0", bus3.port_valid); end
  endtask

  task automatic test_latch();
    bus.out_wr = 1'b1; bus.ch_sel = 2'd0; bus.bus_in = 32'h0000_00A5;
    step();
    bus.out_wr = 1'b0;
    n_cmp++; if (pd(0) !== 32'hA5) begin n_fail++; $display("FAIL latch_data: got %h expected a5", pd(0)); end
    n_cmp++; if (bus.port_valid[0] !== 1'b1) begin n_fail++; $display("FAIL latch_valid: got %b expected 1", bus.port_valid[0]); end
    bus.port_ready[0] = 1'b1; bus.bus_in = 32'hFFFF_FFFF;
    step();
    bus.port_ready[0] = 1'b0;
    n_cmp++; if (pd(0) !== 32'hA5) begin n_fail++; $display("FAIL latch_hold: got %h expected a5", pd(0)); end
    n_cmp++; if (bus.port_valid[0] !== 1'b1) begin n_fail++; $display("FAIL latch_hold_valid: got %b expected 1", bus.port_valid[0]); end
    #2 clr = 1'b1;
    #1;
    n_cmp++; if (pd(0) !== 32'h0) begin n_fail++; $display("FAIL async_rst_data: got %h expected 0", pd(0)); end
    n_cmp++; if (bus.port_valid !== 4'h0) begin n_fail++; $display("FAIL async_rst_valid: got %h expected 0", bus.port_valid); end
    #3 clr = 1'b0;
    step();
  endtask

  task automatic test_stream();
    logic [31:0] vals [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    mode = 4'b0010; bus.port_ready = '0;
    step();
    for (int k = 0; k < 4; k++) begin
      bus.out_wr = 1'b1; bus.ch_sel = 2'd1; bus.bus_in = vals[k];
      #1;
      if (k == 3) begin
        n_cmp++; if (bus.wr_stall !== 1'b0) begin n_fail++; $display("FAIL stream_nostall: got %b expected 0", bus.wr_stall); end
      end
      step();
    end
    bus.out_wr = 1'b0;
    n_cmp++; if (bus.port_valid[1] !== 1'b1) begin n_fail++; $display("FAIL stream_valid: got %b expected 1", bus.port_valid[1]); end
    n_cmp++; if (pd(1) !== 32'h11) begin n_fail++; $display("FAIL stream_head: got %h expected 11", pd(1)); end
    n_cmp++; if (overflow[1] !== 1'b0) begin n_fail++; $display("FAIL stream_noovf: got %b expected 0", overflow[1]); end
    bus.out_wr = 1'b1; bus.bus_in = 32'h55;
    #1;
    n_cmp++; if (bus.wr_stall !== 1'b1) begin n_fail++; $display("FAIL stream_stall: got %b expected 1", bus.wr_stall); end
    step();
    bus.out_wr = 1'b0;
    n_cmp++; if (overflow[1] !== 1'b1) begin n_fail++; $display("FAIL stream_ovf: got %b expected 1", overflow[1]); end
    bus.port_ready[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (pd(1) !== vals[k]) begin n_fail++; $display("FAIL stream_drain%0d: got %h expected %h", k, pd(1), vals[k]); end
      step();
    end
    bus.port_ready[1] = 1'b0;
    n_cmp++; if (bus.port_valid[1] !== 1'b0) begin n_fail++; $display("FAIL stream_empty: got %b expected 0", bus.port_valid[1]); end
  endtask

  task automatic test_ovf();
    ovf_clr = 4'b0010;
    step();
    ovf_clr = '0;
    n_cmp++; if (overflow[1] !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", overflow[1]); end
    for (int k = 1; k <= 4; k++) begin
      bus.out_wr = 1'b1; bus.ch_sel = 2'd1; bus.bus_in = 32'(k * 'h11);
      step();
    end
    bus.out_wr = 1'b1; bus.bus_in = 32'h55; ovf_clr = 4'b0010;
    #1;
    n_cmp++; if (bus.wr_stall !== 1'b1) begin n_fail++; $display("FAIL ovf_stall: got %b expected 1", bus.wr_stall); end
    step();
    bus.out_wr = 1'b0; ovf_clr = '0;
    n_cmp++; if (overflow[1] !== 1'b1) begin n_fail++; $display("FAIL ovf_priority: got %b expected 1", overflow[1]); end
    ovf_clr = 4'b0010;
    step();
    ovf_clr = '0;
    n_cmp++; if (overflow[1] !== 1'b0) begin n_fail++; $display("FAIL ovf_clear2: got %b expected 0", overflow[1]); end
  endtask

  task automatic test_full_pushpop();
    logic [31:0] vals [4] = '{32'h22, 32'h33, 32'h44, 32'h99};
    bus.port_ready[1] = 1'b1; bus.out_wr = 1'b1; bus.ch_sel = 2'd1; bus.bus_in = 32'h99;
    #1;
    n_cmp++; if (bus.wr_stall !== 1'b0) begin n_fail++; $display("FAIL pp_stall: got %b expected 0", bus.wr_stall); end
    step();
    bus.out_wr = 1'b0; bus.port_ready[1] = 1'b0;
    n_cmp++; if (overflow[1] !== 1'b0) begin n_fail++; $display("FAIL pp_ovf: got %b expected 0", overflow[1]); end
    n_cmp++; if (pd(1) !== 32'h22) begin n_fail++; $display("FAIL pp_head: got %h expected 22", pd(1)); end
    bus.out_wr = 1'b1; bus.bus_in = 32'hAA;
    #1;
    n_cmp++; if (bus.wr_stall !== 1'b1) begin n_fail++; $display("FAIL pp_still_full: got %b expected 1", bus.wr_stall); end
    bus.out_wr = 1'b0;
    #1;
    bus.port_ready[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (pd(1) !== vals[k]) begin n_fail++; $display("FAIL pp_drain%0d: got %h expected %h", k, pd(1), vals[k]); end
      step();
    end
    bus.port_ready[1] = 1'b0;
    n_cmp++; if (bus.port_valid[1] !== 1'b0) begin n_fail++; $display("FAIL pp_empty: got %b expected 0", bus.port_valid[1]); end
  endtask

  task automatic test_wrap();
    mode = 4'b0110;
    step();
    for (int v = 1; v <= 10; v++) begin
      bus.out_wr = 1'b1; bus.ch_sel = 2'd2; bus.bus_in = 32'(v);
      step();
      bus.out_wr = 1'b0;
      n_cmp++; if (pd(2) !== 32'(v)) begin n_fail++; $display("FAIL wrap_data%0d: got %h expected %h", v, pd(2), 32'(v)); end
      n_cmp++; if (bus.port_valid[2] !== 1'b1) begin n_fail++; $display("FAIL wrap_valid%0d: got %b expected 1", v, bus.port_valid[2]); end
      bus.port_ready[2] = 1'b1;
      step();
      bus.port_ready[2] = 1'b0;
      n_cmp++; if (bus.port_valid[2] !== 1'b0) begin n_fail++; $display("FAIL wrap_pop%0d: got %b expected 0", v, bus.port_valid[2]); end
    end
  endtask

  task automatic test_mode_flush();
    mode = 4'b1110;
    step();
    bus.out_wr = 1'b1; bus.ch_sel = 2'd3; bus.bus_in = 32'hA1;
    step();
    bus.bus_in = 32'hA2;
    step();
    bus.out_wr = 1'b0;
    n_cmp++; if (pd(3) !== 32'hA1) begin n_fail++; $display("FAIL flush_pre_head: got %h expected a1", pd(3)); end
    mode = 4'b0110; bus.out_wr = 1'b1; bus.bus_in = 32'h5;
    step();
    bus.out_wr = 1'b0;
    n_cmp++; if (bus.port_valid[3] !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", bus.port_valid[3]); end
    n_cmp++; if (pd(3) !== 32'h0) begin n_fail++; $display("FAIL flush_data: got %h expected 0", pd(3)); end
    bus.out_wr = 1'b1; bus.bus_in = 32'hDEAD_BEEF;
    step();
    bus.out_wr = 1'b0; bus.port_ready[3] = 1'b1;
    step();
    step();
    bus.port_ready[3] = 1'b0;
    n_cmp++; if (pd(3) !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL flush_latch: got %h expected deadbeef", pd(3)); end
    n_cmp++; if (bus.port_valid[3] !== 1'b1) begin n_fail++; $display("FAIL flush_latch_valid: got %b expected 1", bus.port_valid[3]); end
  endtask

  task automatic test_bad_sel();
    bus3.out_wr = 1'b1; bus3.ch_sel = 2'd3; bus3.bus_in = 32'h1234;
    step();
    bus3.out_wr = 1'b0;
    n_cmp++; if (bus3.port_valid !== 3'h0) begin n_fail++; $display("FAIL badsel_valid: got %h expected 0", bus3.port_valid); end
    n_cmp++; if (bus3.port_data !== '0) begin n_fail++; $display("FAIL badsel_data: got %h expected 0", bus3.port_data); end
    n_cmp++; if (overflow3 !== 3'h0) begin n_fail++; $display("FAIL badsel_ovf: got %h expected 0", overflow3); end
    bus3.out_wr = 1'b1; bus3.ch_sel = 2'd2; bus3.bus_in = 32'h77;
    step();
    bus3.out_wr = 1'b0;
    n_cmp++; if (bus3.port_valid !== 3'b100) begin n_fail++; $display("FAIL sel2_valid: got %b expected 100", bus3.port_valid); end
    n_cmp++; if (bus3.port_data[64 +: 32] !== 32'h77) begin n_fail++; $display("FAIL sel2_data: got %h expected 77", bus3.port_data[64 +: 32]); end
  endtask

  task automatic test_random();
    do_reset();
    model_reset();
    mode = 4'b0110;
    for (int n = 0; n < 400; n++) begin
      logic wr;
      logic [1:0] sel;
      logic [31:0] d;
      logic [3:0] md, rdy, oc, eo;
      wr  = ($urandom_range(0, 9) < 7);
      sel = 2'($urandom_range(0, 3));
      d   = $urandom;
      oc  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      md  = mode;
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 49) == 0) md[c] = ~md[c];
        rdy[c] = ($urandom_range(0, 99) < (((n / 40) % 2) ? 80 : 5));
      end
      bus.out_wr = wr; bus.ch_sel = sel; bus.bus_in = d; bus.port_ready = rdy;
      mode = md; ovf_clr = oc;
      #1;
      n_cmp++;
      if (bus.wr_stall !== exp_stall(wr, sel, rdy)) begin
        n_fail++; $display("FAIL rnd_stall@%0d: got %b expected %b", n, bus.wr_stall, exp_stall(wr, sel, rdy));
      end
      step();
      model_edge(wr, sel, d, md, rdy, oc);
      for (int c = 0; c < NCH; c++) begin
        eo[c] = m_ovf[c];
        n_cmp++;
        if (pd(c) !== exp_d(c)) begin n_fail++; $display("FAIL rnd_data%0d@%0d: got %h expected %h", c, n, pd(c), exp_d(c)); end
        n_cmp++;
        if (bus.port_valid[c] !== exp_v(c)) begin n_fail++; $display("FAIL rnd_valid%0d@%0d: got %b expected %b", c, n, bus.port_valid[c], exp_v(c)); end
      end
      n_cmp++;
      if (overflow !== eo) begin n_fail++; $display("FAIL rnd_ovf@%0d: got %h expected %h", n, overflow, eo); end
    end
    bus.out_wr = 1'b0; bus.port_ready = '0; ovf_clr = '0;
    #2 clr = 1'b1;
    #1;
    n_cmp++; if (bus.port_valid !== 4'h0) begin n_fail++; $display("FAIL rnd_rst_valid: got %h expected 0", bus.port_valid); end
    n_cmp++; if (overflow !== 4'h0) begin n_fail++; $display("FAIL rnd_rst_ovf: got %h expected 0", overflow); end
    #3 clr = 1'b0;
  endtask

  initial begin
    clr = 1'b1;
    test_reset();
    test_latch();
    test_stream();
    test_ovf();
    test_full_pushpop();
    test_wrap();
    test_mode_flush();
    test_bad_sel();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
